// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 3-stage pipeline stall/flush/bubble, dmem handshake and trap sequencer
// Optional stall performance counter enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCsrc,
    input  logic             reg_wrMW,
    input  logic [1:0]       wb_selMW,
    input  logic [4:0]       waddr_MW,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    input  logic             mem_enMW,
    input  logic             dmem_ack,
    input  logic             irq,
    output logic             stall_F,
    output logic             stall_E,
    output logic             stall_MW,
    output logic             flush_E,
    output logic             bubble_MW,
    output logic             dmem_req,
    output logic             trap_take,
    output logic             bus_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP_DRAIN, TRAP} state_t;

    state_t            state;
    state_t            next_state;
    logic [WCNT_W-1:0] wcnt;
    logic              load_use;

    assign load_use = (wb_selMW == 2'b10) && reg_wrMW &&
                      (((raddr1 == waddr_MW) && (raddr1 != 5'd0)) ||
                       ((raddr2 == waddr_MW) && (raddr2 != 5'd0)));

    always_comb begin
        next_state = state;
        stall_F    = 1'b0;
        stall_E    = 1'b0;
        stall_MW   = 1'b0;
        flush_E    = 1'b0;
        bubble_MW  = 1'b0;
        dmem_req   = 1'b0;
        trap_take  = 1'b0;
        bus_err    = 1'b0;
        case (state)
            RUN: begin
                dmem_req = mem_enMW;
                if (mem_enMW && !dmem_ack) begin
                    stall_F    = 1'b1;
                    stall_E    = 1'b1;
                    stall_MW   = 1'b1;
                    next_state = MEM_WAIT;
                end else if (irq && !PCsrc) begin
                    // Branch redirect wins first so the trap saves a clean PC.
                    flush_E    = 1'b1;
                    stall_F    = 1'b1;
                    next_state = TRAP_DRAIN;
                end else if (PCsrc) begin
                    flush_E = 1'b1;
                end else if (load_use) begin
                    stall_F   = 1'b1;
                    stall_E   = 1'b1;
                    bubble_MW = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    next_state = RUN;
                end else if (wcnt == WCNT_LAST) begin
                    bus_err    = 1'b1;
                    bubble_MW  = 1'b1;
                    stall_F    = 1'b1;
                    stall_E    = 1'b1;
                    next_state = TRAP;
                end else begin
                    stall_F  = 1'b1;
                    stall_E  = 1'b1;
                    stall_MW = 1'b1;
                end
            end
            TRAP_DRAIN: begin
                flush_E    = 1'b1;
                stall_F    = 1'b1;
                bubble_MW  = 1'b1;
                next_state = TRAP;
            end
            default: begin
                trap_take  = 1'b1;
                flush_E    = 1'b1;
                next_state = RUN;
            end
        endcase
        // Hold every control quiet while the core is in reset.
        if (!rst_n) begin
            stall_F   = 1'b0;
            stall_E   = 1'b0;
            stall_MW  = 1'b0;
            flush_E   = 1'b0;
            bubble_MW = 1'b0;
            dmem_req  = 1'b0;
            trap_take = 1'b0;
            bus_err   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            if (state == RUN)
                wcnt <= '0;
            else if (state == MEM_WAIT)
                wcnt <= wcnt + 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_F && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule
